opv_bias_sweep: RTL and testbench
=================================

OPV_BIAS_SWEEP -- requirements
Module: opv_bias_sweep

Interface
REQ-001 SHALL have parameter NCH, default 4: number of op-amp channels swept; legal range 1..16.
REQ-002 SHALL have parameter CODE_W, default 8: bias-current DAC code width.
REQ-003 SHALL have parameter DATA_W, default 12: ADC sample width.
REQ-004 SHALL have parameter SETTLE_W, default 16: settle-counter width.
REQ-005 SHALL have parameter TMO_CYC, default 1024: ADC acknowledge timeout in cycles.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1: one-cycle sweep launch pulse.
REQ-009 SHALL have port settle_cyc, input, SETTLE_W: RC settle wait per point.
REQ-010 SHALL have ports code_start, code_step, code_stop, input, CODE_W each: sweep range.
REQ-011 SHALL have port ch_sel, output, clog2(NCH) (minimum 1): channel under test.
REQ-012 SHALL have port bias_code, output, CODE_W: DAC code driven to the current source.
REQ-013 SHALL have ports adc_req (output, 1), adc_ack (input, 1), adc_data (input, DATA_W): conversion handshake.
REQ-014 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_ch, res_code, res_data (outputs): result stream.
REQ-015 SHALL have ports busy, done, err_tmo, output, 1 each: status.

Function
REQ-016 SHALL implement the FSM IDLE -> SETTLE -> CONVERT -> EMIT -> NEXT -> SETTLE or IDLE.
REQ-017 SHALL, in IDLE, latch settle_cyc and the three code inputs on start, set ch_sel=0 and bias_code=code_start, and enter SETTLE on the next cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL remain in SETTLE for exactly settle_cyc cycles; settle_cyc=0 SHALL mean 1 cycle.
REQ-020 SHALL, in CONVERT, hold adc_req=1 until the cycle adc_ack=1, capture adc_data in that cycle, drop adc_req on the following cycle, and enter EMIT.
REQ-021 SHALL, if adc_ack has not arrived after TMO_CYC cycles in CONVERT, set err_tmo=1 (sticky until the next start), emit a result with res_data all ones, and continue the sweep.
REQ-022 SHALL, in EMIT, assert res_valid with stable res_ch/res_code/res_data until the cycle res_valid and res_ready are both high; no result SHALL be dropped or duplicated.
REQ-023 SHALL, in NEXT, advance bias_code by code_step if code+step <= code_stop with no CODE_W overflow; otherwise reset bias_code to code_start and increment ch_sel.
REQ-024 SHALL treat code_step=0 or code_start>code_stop as a single point per channel.
REQ-025 SHALL, after the last point of channel NCH-1, return to IDLE and pulse done for one cycle.
REQ-026 SHALL hold busy=1 in every state except IDLE.
REQ-027 SHALL keep bias_code and ch_sel unchanged in SETTLE, CONVERT and EMIT.

Reset
REQ-028 SHALL, on rst, force IDLE, ch_sel=0, bias_code=0, adc_req=0, res_valid=0, res_ch=0, res_code=0, res_data=0, busy=0, done=0, err_tmo=0.
REQ-029 SHALL, on rst asserted mid-sweep (including during an open ADC handshake), abort immediately; a late adc_ack SHALL be ignored.

Structure
REQ-030 SHALL place the FSM state enum and the all-ones timeout sentinel in the shared package opv_pkg.
REQ-031 SHALL implement the settle/timeout down-counter as one sub-module, opv_wait_cnt, reused by SETTLE and CONVERT.

Verification
REQ-032 SHALL test: NCH=2, code 10..30 step 10, settle_cyc=5, ack after 3 cycles -> 6 results (ch0 and ch1, codes 10/20/30), done pulses once.
REQ-033 SHALL test: code_start=250, step=10, stop=255 (CODE_W=8) -> 1 point per channel, no wrap to 4.
REQ-034 SHALL test: adc_ack never asserted, TMO_CYC=16 -> err_tmo=1 and res_data=0xFFF for every point, sweep completes.
REQ-035 SHALL test: res_ready held low 20 cycles in EMIT -> res_valid and data stable, then accepted exactly once.
REQ-036 SHALL test: start pulsed while busy -> no effect; rst during CONVERT with ack on the next cycle -> IDLE, all outputs at reset values.
REQ-037 SHALL test: settle_cyc=0 -> adc_req rises 1 cycle after SETTLE entry.

Source files
------------

// File: rtl/opv_pkg.sv
// Shared definitions for the op-amp bias-current sweep controller.
package opv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StConvert,
        StEmit,
        StNext
    } opv_state_e;

    // Result data reported for a point whose conversion never completed; sliced to DATA_W by users.
    localparam int unsigned AdcSentinelMaxW = 64;
    localparam logic [AdcSentinelMaxW-1:0] AdcTmoSentinel = '1;

endpackage

// File: rtl/opv_wait_cnt.sv
// Loadable down-counter shared by the settle wait and the ADC acknowledge timeout.
module opv_wait_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Loading N-1 makes zero_o rise after exactly N cycles in the waiting state.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/opv_bias_sweep.sv
// Sweeps a bias-current DAC code over each op-amp channel, settles, converts and streams results.
module opv_bias_sweep
    import opv_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CODE_W   = 8,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned SETTLE_W = 16,
    parameter int unsigned TMO_CYC  = 1024,
    localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic [CODE_W-1:0]   code_start,
    input  logic [CODE_W-1:0]   code_step,
    input  logic [CODE_W-1:0]   code_stop,
    output logic [CH_W-1:0]     ch_sel,
    output logic [CODE_W-1:0]   bias_code,
    output logic                adc_req,
    input  logic                adc_ack,
    input  logic [DATA_W-1:0]   adc_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [CH_W-1:0]     res_ch,
    output logic [CODE_W-1:0]   res_code,
    output logic [DATA_W-1:0]   res_data,
    output logic                busy,
    output logic                done,
    output logic                err_tmo
);

    localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
    localparam int unsigned CntW = (SETTLE_W > TmoW) ? SETTLE_W : TmoW;
    localparam logic [CH_W-1:0] ChLast = CH_W'(NCH - 1);
    localparam logic [CntW-1:0] TmoLoad = CntW'(TMO_CYC - 1);

    opv_state_e state_q, state_d;

    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [CODE_W-1:0]   cstart_q, cstart_d;
    logic [CODE_W-1:0]   cstep_q, cstep_d;
    logic [CODE_W-1:0]   cstop_q, cstop_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [CODE_W-1:0]   res_code_q, res_code_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic            cnt_load;
    logic [CntW-1:0] cnt_val;
    logic            cnt_zero;

    logic [SETTLE_W-1:0] settle_in_m1, settle_q_m1;
    logic [CODE_W:0]     code_sum;
    logic                step_ok;

    // settle_cyc of 0 behaves like 1, so both map to a zero reload.
    assign settle_in_m1 = (settle_cyc == '0) ? '0 : settle_cyc - SETTLE_W'(1);
    assign settle_q_m1  = (settle_q == '0) ? '0 : settle_q - SETTLE_W'(1);

    // One extra bit catches CODE_W overflow of code + step.
    assign code_sum = {1'b0, code_q} + {1'b0, cstep_q};
    assign step_ok  = (cstep_q != '0) && (cstart_q <= cstop_q) && (code_sum <= {1'b0, cstop_q});

    opv_wait_cnt #(
        .Width (CntW)
    ) u_wait_cnt (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        code_d     = code_q;
        settle_d   = settle_q;
        cstart_d   = cstart_q;
        cstep_d    = cstep_q;
        cstop_d    = cstop_q;
        res_ch_d   = res_ch_q;
        res_code_d = res_code_q;
        res_data_d = res_data_q;
        done_d     = 1'b0;
        err_d      = err_q;
        cnt_load   = 1'b0;
        cnt_val    = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    settle_d = settle_cyc;
                    cstart_d = code_start;
                    cstep_d  = code_step;
                    cstop_d  = code_stop;
                    ch_d     = '0;
                    code_d   = code_start;
                    err_d    = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(settle_in_m1);
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = TmoLoad;
                    state_d  = StConvert;
                end
            end
            StConvert: begin
                if (adc_ack) begin
                    res_ch_d   = ch_q;
                    res_code_d = code_q;
                    res_data_d = adc_data;
                    state_d    = StEmit;
                end else if (cnt_zero) begin
                    res_ch_d   = ch_q;
                    res_code_d = code_q;
                    res_data_d = AdcTmoSentinel[DATA_W-1:0];
                    err_d      = 1'b1;
                    state_d    = StEmit;
                end
            end
            StEmit: begin
                if (res_ready) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (step_ok) begin
                    code_d   = code_sum[CODE_W-1:0];
                    cnt_load = 1'b1;
                    cnt_val  = CntW'(settle_q_m1);
                    state_d  = StSettle;
                end else begin
                    code_d = cstart_q;
                    if (ch_q == ChLast) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ch_d     = ch_q + CH_W'(1);
                        cnt_load = 1'b1;
                        cnt_val  = CntW'(settle_q_m1);
                        state_d  = StSettle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            code_q     <= '0;
            settle_q   <= '0;
            cstart_q   <= '0;
            cstep_q    <= '0;
            cstop_q    <= '0;
            res_ch_q   <= '0;
            res_code_q <= '0;
            res_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            code_q     <= code_d;
            settle_q   <= settle_d;
            cstart_q   <= cstart_d;
            cstep_q    <= cstep_d;
            cstop_q    <= cstop_d;
            res_ch_q   <= res_ch_d;
            res_code_q <= res_code_d;
            res_data_q <= res_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign ch_sel    = ch_q;
    assign bias_code = code_q;
    assign adc_req   = (state_q == StConvert);
    assign res_valid = (state_q == StEmit);
    assign res_ch    = res_ch_q;
    assign res_code  = res_code_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err_tmo   = err_q;

endmodule

// File: tb/tb_opv_bias_sweep.sv
// Directed bench for opv_bias_sweep: two channels, 8-bit codes, 12-bit ADC, 16-cycle ADC timeout.
module tb_opv_bias_sweep;

    localparam int unsigned NCH      = 2;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned SETTLE_W = 16;
    localparam int unsigned TMO_CYC  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [SETTLE_W-1:0] settle_cyc = '0;
    logic [CODE_W-1:0]   code_start = '0;
    logic [CODE_W-1:0]   code_step = '0;
    logic [CODE_W-1:0]   code_stop = '0;
    logic                ch_sel;
    logic [CODE_W-1:0]   bias_code;
    logic                adc_req;
    logic                adc_ack = 1'b0;
    logic [DATA_W-1:0]   adc_data = '0;
    logic                res_valid;
    logic                res_ready = 1'b1;
    logic                res_ch;
    logic [CODE_W-1:0]   res_code;
    logic [DATA_W-1:0]   res_data;
    logic                busy;
    logic                done;
    logic                err_tmo;

    opv_bias_sweep #(
        .NCH      (NCH),
        .CODE_W   (CODE_W),
        .DATA_W   (DATA_W),
        .SETTLE_W (SETTLE_W),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .settle_cyc (settle_cyc),
        .code_start (code_start),
        .code_step  (code_step),
        .code_stop  (code_stop),
        .ch_sel     (ch_sel),
        .bias_code  (bias_code),
        .adc_req    (adc_req),
        .adc_ack    (adc_ack),
        .adc_data   (adc_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ch     (res_ch),
        .res_code   (res_code),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ack_mode = 0;   // 0: ack after ack_delay cycles, 1: never ack, 2: ack whenever rst is low
    int ack_delay = 3;
    int done_cnt = 0;
    int got_ch[$];
    int got_code[$];
    int got_data[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ADC model: data encodes the channel and code under test.
    initial begin : adc_model
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (ack_mode == 2) begin
                adc_ack  = !rst;
                adc_data = 12'hABC;
            end else if (ack_mode == 0 && adc_req && !adc_ack) begin
                n++;
                if (n >= ack_delay) begin
                    adc_ack  = 1'b1;
                    adc_data = {3'b000, ch_sel, bias_code};
                end
            end else begin
                adc_ack = 1'b0;
                n = 0;
            end
        end
    end

    initial begin : res_monitor
        forever begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                got_ch.push_back(int'(res_ch));
                got_code.push_back(int'(res_code));
                got_data.push_back(int'(res_data));
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_results();
        got_ch.delete();
        got_code.delete();
        got_data.delete();
    endtask

    task automatic start_sweep(input int st, input int cs, input int step, input int stop,
                               output int lat);
        settle_cyc = SETTLE_W'(st);
        code_start = CODE_W'(cs);
        code_step  = CODE_W'(step);
        code_stop  = CODE_W'(stop);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (!adc_req && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic check_point(input string tag, input int k, input int ch, input int code,
                               input int data);
        if (k < got_ch.size()) begin
            check_val({tag, "_ch"}, got_ch[k], ch);
            check_val({tag, "_code"}, got_code[k], code);
            check_val({tag, "_data"}, got_data[k], data);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat;
        int d0;
        int bad;
        logic [DATA_W-1:0] held_data;
        logic [CODE_W-1:0] held_code;
        logic held_ch;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err_tmo, 0);
        check_val("rst_req", adc_req, 0);
        check_val("rst_valid", res_valid, 0);
        check_val("rst_ch_sel", ch_sel, 0);
        check_val("rst_bias", bias_code, 0);
        check_val("rst_res_data", res_data, 0);

        // Basic sweep: 10..30 step 10 on both channels, settle 5, ack after 3 cycles.
        clear_results();
        ack_mode = 0;
        ack_delay = 3;
        d0 = done_cnt;
        start_sweep(5, 10, 10, 30, lat);
        check_val("settle5_latency", lat, 6);
        check_val("busy_in_sweep", busy, 1);
        wait_done("basic_done", 500);
        repeat (5) @(negedge clk);
        check_val("basic_done_once", done_cnt - d0, 1);
        check_val("basic_count", got_ch.size(), 6);
        for (int k = 0; k < 6; k++) begin
            check_point("basic", k, k / 3, 10 + 10 * (k % 3), ((k / 3) << 8) | (10 + 10 * (k % 3)));
        end
        check_val("basic_err", err_tmo, 0);
        check_val("basic_idle", busy, 0);

        // 250 + 10 overflows the 8-bit code: one point per channel.
        clear_results();
        start_sweep(1, 250, 10, 255, lat);
        wait_done("ovf_done", 300);
        repeat (2) @(negedge clk);
        check_val("ovf_count", got_ch.size(), 2);
        check_point("ovf0", 0, 0, 250, 250);
        check_point("ovf1", 1, 1, 250, 256 + 250);

        // No acknowledge at all: each point times out with the all-ones sentinel.
        clear_results();
        ack_mode = 1;
        start_sweep(1, 10, 10, 20, lat);
        wait_done("tmo_done", 500);
        repeat (2) @(negedge clk);
        check_val("tmo_err", err_tmo, 1);
        check_val("tmo_count", got_ch.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_point("tmo", k, k / 2, 10 + 10 * (k % 2), 12'hFFF);
        end

        // Back-pressure: result held for 20 cycles, then accepted exactly once.
        clear_results();
        ack_mode = 0;
        res_ready = 1'b0;
        start_sweep(2, 5, 0, 5, lat);
        check_val("err_cleared", err_tmo, 0);
        lat = 0;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_val("stall_valid", res_valid, 1);
        held_ch = res_ch;
        held_code = res_code;
        held_data = res_data;
        check_val("stall_data", held_data, 5);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!res_valid || res_ch !== held_ch || res_code !== held_code
                || res_data !== held_data) bad++;
        end
        check_val("stall_stable", bad, 0);
        check_val("stall_none_taken", got_ch.size(), 0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done("stall_done", 300);
        repeat (2) @(negedge clk);
        check_val("stall_count", got_ch.size(), 2);
        check_point("stall0", 0, 0, 5, 5);
        check_point("stall1", 1, 1, 5, 256 + 5);

        // start while busy must not restart or alter the sweep.
        clear_results();
        start_sweep(5, 5, 0, 5, lat);
        settle_cyc = '0;
        code_start = 8'd99;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy_start_done", 300);
        repeat (2) @(negedge clk);
        check_val("busy_start_count", got_ch.size(), 2);
        check_point("busy_start0", 0, 0, 5, 5);
        check_point("busy_start1", 1, 1, 5, 256 + 5);

        // settle_cyc = 0 behaves as a single settle cycle.
        clear_results();
        start_sweep(0, 7, 0, 7, lat);
        check_val("settle0_latency", lat, 2);
        wait_done("settle0_done", 300);

        // Reset inside CONVERT, with acknowledge arriving the cycle after reset.
        clear_results();
        ack_delay = 10;
        start_sweep(1, 40, 1, 60, lat);
        check_val("pre_rst_req", adc_req, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        ack_mode = 2;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("abort_busy", busy, 0);
        check_val("abort_req", adc_req, 0);
        check_val("abort_valid", res_valid, 0);
        check_val("abort_ch_sel", ch_sel, 0);
        check_val("abort_bias", bias_code, 0);
        check_val("abort_res_code", res_code, 0);
        check_val("abort_res_data", res_data, 0);
        check_val("abort_done", done, 0);
        check_val("abort_err", err_tmo, 0);
        check_val("late_ack_present", adc_ack, 1);
        @(posedge clk);
        #1 ack_mode = 0;
        repeat (10) @(negedge clk);
        check_val("late_ack_busy", busy, 0);
        check_val("late_ack_valid", res_valid, 0);
        check_val("late_ack_res_data", res_data, 0);
        check_val("late_ack_count", got_ch.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
